ram_arbiter: RTL

- Sequenced arbiter that shares the single RAM port between CPUS cores.
- Each core has one instruction channel and one data channel.
- Latches one winning request per transaction and holds it until RAM reports ACCESS. Rotates fairness between cores round-robin.
- Sits between the per-core cache controllers and the RAM model; it replaces the combinational single-core memory path for multicore builds.

---
 rtl/ram_arbiter.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one RAM port between CPUS cores (instruction + data channel each).
// Optional grant watchdog enabled by defining ARB_TIMEOUT_EN.
module ram_arbiter #(
    parameter int CPUS           = 2,
    parameter int WORD_W         = 32,
    parameter int TIMEOUT_CYCLES = 64,
    localparam int PTR_W         = (CPUS > 2) ? 2 : 1
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [CPUS-1:0]          iREN,
    input  logic [CPUS-1:0]          dREN,
    input  logic [CPUS-1:0]          dWEN,
    input  logic [CPUS*WORD_W-1:0]   iaddr,
    input  logic [CPUS*WORD_W-1:0]   daddr,
    input  logic [CPUS*WORD_W-1:0]   dstore,
    output logic [CPUS-1:0]          iwait,
    output logic [CPUS-1:0]          dwait,
    output logic [CPUS*WORD_W-1:0]   iload,
    output logic [CPUS*WORD_W-1:0]   dload,
    output logic                     ramREN,
    output logic                     ramWEN,
    output logic [WORD_W-1:0]        ramaddr,
    output logic [WORD_W-1:0]        ramstore,
    input  logic [WORD_W-1:0]        ramload,
    input  logic [1:0]               ramstate,
    output logic                     arb_err,
    output logic                     arb_state,
    output logic [PTR_W-1:0]         rr_ptr
);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] GRANT = 1'b1;

    localparam logic [1:0] GT_WR = 2'd0;
    localparam logic [1:0] GT_RD = 2'd1;
    localparam logic [1:0] GT_IF = 2'd2;

    localparam logic [1:0] RS_ACCESS = 2'd2;
    localparam logic [1:0] RS_ERROR  = 2'd3;

    if (CPUS < 2 || CPUS > 4 || TIMEOUT_CYCLES < 1) begin : g_bad_config
        $error("ram_arbiter: CPUS must be 2..4 and TIMEOUT_CYCLES >= 1");
    end

    logic [0:0]       state;
    logic [PTR_W-1:0] gcore;
    logic [1:0]       gtype;

    logic [WORD_W-1:0] iaddr_a  [CPUS];
    logic [WORD_W-1:0] daddr_a  [CPUS];
    logic [WORD_W-1:0] dstore_a [CPUS];

    for (genvar k = 0; k < CPUS; k++) begin : g_unpack
        assign iaddr_a[k]  = iaddr[k*WORD_W +: WORD_W];
        assign daddr_a[k]  = daddr[k*WORD_W +: WORD_W];
        assign dstore_a[k] = dstore[k*WORD_W +: WORD_W];
    end

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(CPUS - 1)) ? '0 : p + 1'b1;
    endfunction

    // Round-robin pick: first requesting core at or after rr_ptr.
    logic [CPUS-1:0]  req;
    logic             any_req;
    logic             found;
    logic [PTR_W-1:0] idx;
    logic [PTR_W-1:0] pick_core;
    logic [1:0]       pick_type;

    assign req     = dWEN | dREN | iREN;
    assign any_req = |req;

    always_comb begin
        found     = 1'b0;
        pick_core = '0;
        idx       = rr_ptr;
        for (int i = 0; i < CPUS; i++) begin
            if (!found && req[idx]) begin
                found     = 1'b1;
                pick_core = idx;
            end
            idx = next_ptr(idx);
        end
        if (dWEN[pick_core])      pick_type = GT_WR;
        else if (dREN[pick_core]) pick_type = GT_RD;
        else                      pick_type = GT_IF;
    end

    // Handshake: a core's wait stays high until the single cycle in which its
    // granted request sees ramstate==ACCESS; that cycle the wait drops and the
    // matching load output carries ramload. A withdrawn or reset grant never pulses.
    logic still_req;
    logic active;
    logic granted;
    logic access;
    logic timeout;

    always_comb begin
        case (gtype)
            GT_WR:   still_req = dWEN[gcore];
            GT_RD:   still_req = dREN[gcore];
            default: still_req = iREN[gcore];
        endcase
    end

    assign active  = (state == GRANT) && !RST;
    assign granted = active && still_req;
    assign access  = granted && (ramstate == RS_ACCESS);

    always_comb begin
        iwait    = '1;
        dwait    = '1;
        iload    = '0;
        dload    = '0;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        if (active) begin
            ramaddr = (gtype == GT_IF) ? iaddr_a[gcore] : daddr_a[gcore];
            if (gtype == GT_WR) ramstore = dstore_a[gcore];
        end
        if (granted) begin
            ramWEN = (gtype == GT_WR);
            ramREN = (gtype != GT_WR);
        end
        for (int k = 0; k < CPUS; k++) begin
            if (access && gcore == PTR_W'(k)) begin
                if (gtype == GT_IF) begin
                    iwait[k]                  = 1'b0;
                    iload[k*WORD_W +: WORD_W] = ramload;
                end else begin
                    dwait[k]                  = 1'b0;
                    dload[k*WORD_W +: WORD_W] = ramload;
                end
            end
        end
    end

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] tcnt;

    // Held at zero in IDLE so every GRANT starts counting from zero.
    always_ff @(posedge CLK) begin
        if (RST || state == IDLE) tcnt <= '0;
        else if (!access)         tcnt <= tcnt + 1'b1;
    end

    assign timeout = (tcnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= IDLE;
            rr_ptr  <= '0;
            gcore   <= '0;
            gtype   <= GT_WR;
            arb_err <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        gcore <= pick_core;
                        gtype <= pick_type;
                        state <= GRANT;
                    end
                end
                GRANT: begin
                    if (!still_req) begin
                        state <= IDLE;
                    end else if (ramstate == RS_ACCESS) begin
                        state  <= IDLE;
                        rr_ptr <= next_ptr(gcore);
                    end else begin
                        if (ramstate == RS_ERROR) arb_err <= 1'b1;
                        if (timeout) begin
                            arb_err <= 1'b1;
                            state   <= IDLE;
                            rr_ptr  <= next_ptr(gcore);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign arb_state = state;

endmodule
